video_pattern_source: RTL and testbench

- Video stream transmitter and test source for the grey-scale processing chain.
- Generates raster timing (HSYNC / VSYNC / BLANK) from parameterised porch and sync widths.
- Drives an 8-bit luma pixel (Y0) per clock, aligned with that timing.
- Feeds filter and matrix blocks in place of camera or decoder input, for bring-up and regression.

---
 rtl/video_pattern_source.sv | 114 +++++++++++
 tb/tb_video_pattern_source.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_source.sv
// Raster timing generator with a registered 8-bit luma test pattern.
// Drives HSYNC/VSYNC/BLANK, pixel coordinates and a frame-start pulse.
module video_pattern_source #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   input  logic [7:0]       i_level,
   output logic             o_HSYNC,
   output logic             o_VSYNC,
   output logic             o_BLANK,
   output logic [7:0]       o_Y0,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic             SYNC_ON  = (SYNC_POL != 0);

   logic [CNT_W-1:0] h_cnt_reg, v_cnt_reg, h_cnt_next, v_cnt_next;
   logic [1:0]       mode_reg, mode_cur;
   logic [7:0]       level_reg, level_cur;
   logic             at_origin, active, hs_win, vs_win;
   logic [7:0]       pix;

   always_comb begin
      at_origin  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
      // The frame's pattern is taken from the inputs live at the origin so
      // that pixel (0,0) already uses the newly sampled mode/level.
      mode_cur   = at_origin ? i_mode  : mode_reg;
      level_cur  = at_origin ? i_level : level_reg;
      active     = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
      hs_win     = (h_cnt_reg >= H_SYNC_S) && (h_cnt_reg < H_SYNC_E);
      vs_win     = (v_cnt_reg >= V_SYNC_S) && (v_cnt_reg < V_SYNC_E);
      h_cnt_next = h_cnt_reg + CNT_ONE;
      v_cnt_next = v_cnt_reg;
      if (h_cnt_reg == H_LAST) begin
         h_cnt_next = '0;
         v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + CNT_ONE;
      end
      pix = '0;
      if (active) begin
         case (mode_cur)
            2'd0:    pix = h_cnt_reg[7:0];
            2'd1:    pix = v_cnt_reg[7:0];
            2'd2:    pix = {8{h_cnt_reg[3] ^ v_cnt_reg[3]}};
            default: pix = level_cur;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_reg     <= '0;
         v_cnt_reg     <= '0;
         mode_reg      <= '0;
         level_reg     <= '0;
         o_HSYNC       <= ~SYNC_ON;
         o_VSYNC       <= ~SYNC_ON;
         o_BLANK       <= 1'b0;
         o_Y0          <= '0;
         o_x           <= '0;
         o_y           <= '0;
         o_frame_start <= 1'b0;
      end else if (!i_en) begin
         // Idle: park at origin with outputs at their reset levels.
         h_cnt_reg     <= '0;
         v_cnt_reg     <= '0;
         o_HSYNC       <= ~SYNC_ON;
         o_VSYNC       <= ~SYNC_ON;
         o_BLANK       <= 1'b0;
         o_Y0          <= '0;
         o_x           <= '0;
         o_y           <= '0;
         o_frame_start <= 1'b0;
      end else begin
         h_cnt_reg     <= h_cnt_next;
         v_cnt_reg     <= v_cnt_next;
         mode_reg      <= mode_cur;
         level_reg     <= level_cur;
         o_HSYNC       <= hs_win ? SYNC_ON : ~SYNC_ON;
         o_VSYNC       <= vs_win ? SYNC_ON : ~SYNC_ON;
         o_BLANK       <= active;
         o_Y0          <= pix;
         o_x           <= active ? h_cnt_reg : '0;
         o_y           <= active ? v_cnt_reg : '0;
         o_frame_start <= at_origin;
      end
   end

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench: per-cycle scoreboard, timing vector table and corner sequences.
module tb_video_pattern_source;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       en_b = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] level = 8'd0;
   logic [1:0] mode_b = 2'd2;
   logic [7:0] level_b = 8'd0;

   logic        hs, vs, blank, fs;
   logic [7:0]  y0;
   logic [10:0] ox, oy;
   logic        hs_b, vs_b, blank_b, fs_b;
   logic [7:0]  y0_b;
   logic [10:0] ox_b, oy_b;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   video_pattern_source #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(0), .CNT_W(11)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_mode(mode), .i_level(level),
      .o_HSYNC(hs), .o_VSYNC(vs), .o_BLANK(blank), .o_Y0(y0),
      .o_x(ox), .o_y(oy), .o_frame_start(fs)
   );

   video_pattern_source #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(0), .CNT_W(11)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .i_en(en_b), .i_mode(mode_b), .i_level(level_b),
      .o_HSYNC(hs_b), .o_VSYNC(vs_b), .o_BLANK(blank_b), .o_Y0(y0_b),
      .o_x(ox_b), .o_y(oy_b), .o_frame_start(fs_b)
   );

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        blank;
      logic [7:0]  y0;
      logic [10:0] x;
      logic [10:0] y;
      logic        fs;
   } obs_t;

   typedef struct {
      int         k;
      logic       blank, hs, vs, fs;
      logic [7:0] y0;
      int         x, y;
   } vec_t;

   vec_t tbl[15];
   obs_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
   endtask

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      return o;
   endfunction

   function automatic obs_t cur_obs();
      obs_t o;
      o.hs = hs; o.vs = vs; o.blank = blank; o.y0 = y0;
      o.x = ox; o.y = oy; o.fs = fs;
      return o;
   endfunction

   // Reference raster model: expected outputs pushed at each clock edge.
   initial begin
      int mh, mv;
      logic [1:0] mm;
      logic [7:0] ml;
      obs_t e;
      mh = 0; mv = 0; mm = 0; ml = 0;
      forever begin
         @(posedge clk);
         e = reset_obs();
         if (!rst_n) begin
            mh = 0; mv = 0; mm = 0; ml = 0;
         end else if (!en) begin
            mh = 0; mv = 0;
         end else begin
            if (mh == 0 && mv == 0) begin
               mm = mode;
               ml = level;
            end
            if (mh < 8 && mv < 4) begin
               e.blank = 1'b1;
               e.x = 11'(mh);
               e.y = 11'(mv);
               case (mm)
                  2'd0: e.y0 = 8'(mh % 256);
                  2'd1: e.y0 = 8'(mv % 256);
                  2'd2: e.y0 = ((((mh / 8) % 2) ^ ((mv / 8) % 2)) != 0) ? 8'hFF : 8'h00;
                  default: e.y0 = ml;
               endcase
            end
            e.fs = (mh == 0 && mv == 0);
            e.hs = !(mh >= 10 && mh < 13);
            e.vs = !(mv >= 5 && mv < 7);
            mh++;
            if (mh == 16) begin
               mh = 0;
               mv++;
               if (mv == 8) mv = 0;
            end
         end
         exp_q.push_back(e);
      end
   end

   // Scoreboard: pop and compare one expected record per clock.
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("sb", 64'(cur_obs()), 64'(e));
         end
      end
   end

   task automatic run_table();
      for (int k = 0; k < 130; k++) begin
         @(posedge clk);
         #2;
         foreach (tbl[i]) begin
            if (tbl[i].k == k) begin
               check($sformatf("tbl_k%0d", k),
                     64'({blank, hs, vs, fs, y0, ox, oy}),
                     64'({tbl[i].blank, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].y0,
                          11'(tbl[i].x), 11'(tbl[i].y)}));
            end
         end
      end
   endtask

   task automatic wait_fs(input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(posedge clk);
         #2;
         if (fs) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      //          k    blank hs vs fs  y0  x  y
      tbl[0]  = '{0,   1, 1, 1, 1, 8'd0, 0, 0};
      tbl[1]  = '{7,   1, 1, 1, 0, 8'd7, 7, 0};
      tbl[2]  = '{8,   0, 1, 1, 0, 8'd0, 0, 0};
      tbl[3]  = '{10,  0, 0, 1, 0, 8'd0, 0, 0};
      tbl[4]  = '{12,  0, 0, 1, 0, 8'd0, 0, 0};
      tbl[5]  = '{13,  0, 1, 1, 0, 8'd0, 0, 0};
      tbl[6]  = '{19,  1, 1, 1, 0, 8'd3, 3, 1};
      tbl[7]  = '{63,  0, 1, 1, 0, 8'd0, 0, 0};
      tbl[8]  = '{64,  0, 1, 1, 0, 8'd0, 0, 0};
      tbl[9]  = '{79,  0, 1, 1, 0, 8'd0, 0, 0};
      tbl[10] = '{80,  0, 1, 0, 0, 8'd0, 0, 0};
      tbl[11] = '{111, 0, 1, 0, 0, 8'd0, 0, 0};
      tbl[12] = '{112, 0, 1, 1, 0, 8'd0, 0, 0};
      tbl[13] = '{128, 1, 1, 1, 1, 8'd0, 0, 0};
      tbl[14] = '{129, 1, 1, 1, 0, 8'd1, 1, 0};

      // Reset state, then horizontal/vertical timing in mode 0.
      repeat (3) @(negedge clk);
      check("reset", 64'(cur_obs()), 64'(reset_obs()));
      mode = 2'd0;
      en = 1'b1;
      rst_n = 1'b1;
      run_table();

      // Flat level is frozen for the frame and updated at the next frame start.
      @(negedge clk);
      mode = 2'd3;
      level = 8'h5A;
      wait_fs("fs_5a");
      check("flat_first", 64'(y0), 64'h5A);
      repeat (20) @(posedge clk);
      @(negedge clk);
      level = 8'hC3;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #2;
         if (blank) begin
            check("flat_hold", 64'(y0), 64'h5A);
            break;
         end
      end
      wait_fs("fs_c3");
      check("flat_new", 64'(y0), 64'hC3);

      // Enable dropped at h=5, v=2, then re-raised.
      repeat (36) @(posedge clk);
      #2;
      check("pre_drop", 64'({ox, oy}), 64'({11'd4, 11'd2}));
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #2;
      check("drop", 64'(cur_obs()), 64'(reset_obs()));
      repeat (3) @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #2;
      check("restart", 64'({fs, blank, ox, oy, y0}), 64'({1'b1, 1'b1, 11'd0, 11'd0, 8'hC3}));

      // Asynchronous reset mid-line, then the same timing as from cold.
      repeat (20) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 64'(cur_obs()), 64'(reset_obs()));
      mode = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      run_table();

      // Checkerboard on the wider raster.
      @(negedge clk);
      en_b = 1'b1;
      for (int k = 0; k < 8 * 22 + 16; k++) begin
         int h, v;
         @(posedge clk);
         #2;
         h = k % 22;
         v = k / 22;
         if (k == 0) check("chk_fs", 64'({fs_b, blank_b}), 64'({1'b1, 1'b1}));
         if ((v == 0 || v == 8) && h < 16)
            check($sformatf("chk_v%0d_h%0d", v, h), 64'(y0_b),
                  ((h >= 8) != (v >= 8)) ? 64'hFF : 64'h00);
      end
      @(negedge clk);
      en_b = 1'b0;

      repeat (2) @(posedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
